// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate for the selected format
// and queues {imm, tag, illegal} in a 2-entry skid buffer behind valid/ready.
module imm_gen_pipe #(
   parameter int XLEN   = 64,
   parameter bit RVC_EN = 1'b1,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [3:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   localparam int ENT_W = XLEN + TAG_W + 1;

   typedef enum logic [3:0] {
      SEL_I     = 4'd0,
      SEL_S     = 4'd1,
      SEL_B     = 4'd2,
      SEL_U     = 4'd3,
      SEL_J     = 4'd4,
      SEL_SHAMT = 4'd5,
      SEL_ZIMM  = 4'd6,
      SEL_C_I   = 4'd8,
      SEL_C_J   = 4'd9,
      SEL_C_B   = 4'd10,
      SEL_C_LW  = 4'd11
   } sel_e;

   logic [31:0]     raw_c;
   logic            sext_c;
   logic            illegal_c;
   logic [XLEN-1:0] imm_c;
   logic [31:0]     i;

   assign i = in_instr;

   // raw_c is built already sign-extended to 32 bits; sext_c widens it to XLEN
   always_comb begin
      raw_c     = '0;
      sext_c    = 1'b0;
      illegal_c = 1'b0;
      case (sel_e'(in_sel))
         SEL_I:  begin raw_c = {{20{i[31]}}, i[31:20]};                            sext_c = 1'b1; end
         SEL_S:  begin raw_c = {{20{i[31]}}, i[31:25], i[11:7]};                   sext_c = 1'b1; end
         SEL_B:  begin raw_c = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; sext_c = 1'b1; end
         SEL_U:  begin raw_c = {i[31:12], 12'b0};                                  sext_c = 1'b1; end
         SEL_J:  begin raw_c = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; sext_c = 1'b1; end
         SEL_SHAMT: begin
            if (XLEN == 64) begin
               raw_c = {26'b0, i[25:20]};
            end else begin
               raw_c     = {27'b0, i[24:20]};
               illegal_c = i[25];
            end
         end
         SEL_ZIMM: raw_c = {27'b0, i[19:15]};
         SEL_C_I, SEL_C_J, SEL_C_B, SEL_C_LW: begin
            if (RVC_EN) begin
               case (sel_e'(in_sel))
                  SEL_C_I: begin raw_c = {{26{i[12]}}, i[12], i[6:2]}; sext_c = 1'b1; end
                  SEL_C_J: begin
                     raw_c  = {{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
                     sext_c = 1'b1;
                  end
                  SEL_C_B: begin
                     raw_c  = {{23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
                     sext_c = 1'b1;
                  end
                  default: raw_c = {25'b0, i[5], i[12:10], i[6], 2'b0};
               endcase
            end else begin
               illegal_c = 1'b1;
            end
         end
         default: illegal_c = 1'b1;
      endcase
      if (sext_c) imm_c = XLEN'($signed(raw_c));
      else        imm_c = XLEN'(raw_c);
   end

   logic [ENT_W-1:0] mem_q [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   assign in_ready  = !reset && !flush && (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (reset)
               mem_q[gi] <= '0;
            else if (push && (wr_ptr_q == 1'(gi)))
               mem_q[gi] <= {imm_c, in_tag, illegal_c};
         end
      end
   endgenerate

   // flush re-aligns the read pointer so the next push lands at the head
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         rd_ptr_q <= wr_ptr_q;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign {out_imm, out_tag, out_illegal} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: three configurations (64/RVC, 32/RVC, 64/no-RVC) share one
// stimulus stream; each output stream is checked against its own expected queue.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [3:0]  in_sel = '0;
   logic [7:0]  in_tag = '0;
   logic        out_ready = 1'b0;

   logic        a_in_ready, b_in_ready, c_in_ready;
   logic        a_out_valid, b_out_valid, c_out_valid;
   logic [63:0] a_out_imm, c_out_imm;
   logic [31:0] b_out_imm;
   logic [7:0]  a_out_tag, b_out_tag, c_out_tag;
   logic        a_out_ill, b_out_ill, c_out_ill;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(64), .RVC_EN(1'b1), .TAG_W(8)) dut_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_imm(a_out_imm), .out_tag(a_out_tag), .out_illegal(a_out_ill));

   imm_gen_pipe #(.XLEN(32), .RVC_EN(1'b1), .TAG_W(8)) dut_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_imm(b_out_imm), .out_tag(b_out_tag), .out_illegal(b_out_ill));

   imm_gen_pipe #(.XLEN(64), .RVC_EN(1'b0), .TAG_W(8)) dut_c (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(c_out_valid),
      .out_ready(out_ready), .out_imm(c_out_imm), .out_tag(c_out_tag), .out_illegal(c_out_ill));

   typedef struct {
      logic [63:0] imm;
      logic [7:0]  tag;
      logic        ill;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];
   exp_t mon_e;

   // Hand-computed vectors: instr, sel, XLEN=64 result, XLEN=32 result, compressed flag
   logic [31:0] tv_instr [15] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h800000B7,
                                  32'h02109093, 32'h0000BFFD, 32'h0000BFFD, 32'h7FF00093,
                                  32'hFE112E23, 32'h8000006F, 32'h000F8073, 32'h00001005,
                                  32'h00000804, 32'h00000420, 32'hDEADBEEF};
   logic [3:0]  tv_sel [15]   = '{4'd0, 4'd2, 4'd3, 4'd3, 4'd5, 4'd9, 4'd15, 4'd0,
                                  4'd1, 4'd4, 4'd6, 4'd8, 4'd10, 4'd11, 4'd7};
   logic [63:0] tv_e64 [15]   = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
                                  64'hFFFFFFFF80000000, 64'd33, 64'hFFFFFFFFFFFFFFFE, 64'd0,
                                  64'h7FF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFF00000, 64'd31,
                                  64'hFFFFFFFFFFFFFFE1, 64'h30, 64'h48, 64'd0};
   logic        tv_i64 [15]   = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
   logic [31:0] tv_e32 [15]   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h80000000,
                                  32'd1, 32'hFFFFFFFE, 32'd0, 32'h7FF, 32'hFFFFFFFC,
                                  32'hFFF00000, 32'd31, 32'hFFFFFFE1, 32'h30, 32'h48, 32'd0};
   logic        tv_i32 [15]   = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
   logic        tv_comp [15]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};

   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (!reset && out_ready) begin
         if (a_out_valid) begin
            if (q_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_unexpected: got tag=%h expected no output", a_out_tag);
            end else begin
               mon_e = q_a.pop_front();
               $display("out x64 tag=%h imm=%h ill=%0b", a_out_tag, a_out_imm, a_out_ill);
               check("a_imm", a_out_imm, mon_e.imm);
               check("a_tag", 64'(a_out_tag), 64'(mon_e.tag));
               check("a_ill", 64'(a_out_ill), 64'(mon_e.ill));
            end
         end
         if (b_out_valid) begin
            if (q_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_unexpected: got tag=%h expected no output", b_out_tag);
            end else begin
               mon_e = q_b.pop_front();
               check("b_imm", 64'(b_out_imm), mon_e.imm);
               check("b_tag", 64'(b_out_tag), 64'(mon_e.tag));
               check("b_ill", 64'(b_out_ill), 64'(mon_e.ill));
            end
         end
         if (c_out_valid) begin
            if (q_c.size() == 0) begin
               total++; bad++;
               $display("FAIL c_unexpected: got tag=%h expected no output", c_out_tag);
            end else begin
               mon_e = q_c.pop_front();
               check("c_imm", c_out_imm, mon_e.imm);
               check("c_tag", 64'(c_out_tag), 64'(mon_e.tag));
               check("c_ill", 64'(c_out_ill), 64'(mon_e.ill));
            end
         end
      end
   end

   task automatic clear_queues();
      q_a.delete();
      q_b.delete();
      q_c.delete();
   endtask

   // Offer one vector; expectations are queued only once the handshake completes
   task automatic send(int idx, logic [7:0] tag);
      int n = 0;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = tv_instr[idx];
      in_sel   = tv_sel[idx];
      in_tag   = tag;
      while (!a_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!a_in_ready) begin
         check("send_timeout", 64'(a_in_ready), 64'd1);
      end else begin
         e.tag = tag;
         e.imm = tv_e64[idx];  e.ill = tv_i64[idx];
         q_a.push_back(e);
         e.imm = 64'(tv_e32[idx]);  e.ill = tv_i32[idx];
         q_b.push_back(e);
         e.imm = tv_comp[idx] ? 64'd0 : tv_e64[idx];
         e.ill = tv_comp[idx] ? 1'b1 : tv_i64[idx];
         q_c.push_back(e);
         $display("in  idx=%0d tag=%h instr=%h sel=%0d", idx, tag, tv_instr[idx], tv_sel[idx]);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("latency_valid", 64'(a_out_valid), 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(a_in_ready), 64'd0);
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_imm", a_out_imm, 64'd0);
      check("rst_tag", 64'(a_out_tag), 64'd0);
      check("rst_ill", 64'(a_out_ill), 64'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(a_in_ready), 64'd1);

      // Full vector sweep at full throughput
      out_ready = 1'b1;
      for (int k = 0; k < 15; k++) send(k, 8'(8'h10 + k));
      drain();

      // Backpressure: two accepted, third refused, head held stable
      out_ready = 1'b0;
      send(7, 8'd1);
      send(0, 8'd2);
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = tv_instr[8];
      in_sel   = tv_sel[8];
      in_tag   = 8'd3;
      #1;
      check("full_in_ready", 64'(a_in_ready), 64'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("stall_tag", 64'(a_out_tag), 64'd1);
         check("stall_imm", a_out_imm, 64'h7FF);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(8, 8'd3);
      drain();

      // Flush with two entries held
      out_ready = 1'b0;
      send(1, 8'h21);
      send(2, 8'h22);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_in_ready", 64'(a_in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      clear_queues();
      #1;
      check("flush_out_valid", 64'(a_out_valid), 64'd0);
      check("flush_in_ready_after", 64'(a_in_ready), 64'd1);

      // Refill one entry after flush, check it comes out first, then reset mid-run
      send(3, 8'h31);
      check("refill_tag", 64'(a_out_tag), 64'h31);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_in_ready", 64'(a_in_ready), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      clear_queues();
      #1;
      check("midrst_out_valid", 64'(a_out_valid), 64'd0);
      check("midrst_imm", a_out_imm, 64'd0);
      check("midrst_tag", 64'(a_out_tag), 64'd0);
      check("midrst_ill", 64'(a_out_ill), 64'd0);
      check("midrst_imm32", 64'(b_out_imm), 64'd0);
      check("midrst_in_ready_after", 64'(a_in_ready), 64'd1);

      // Traffic still flows after reset
      out_ready = 1'b1;
      send(4, 8'h41);
      send(5, 8'h42);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage. It replaces the purely combinational immediate mux used by the core.
- Accepts a 32-bit instruction word (or a 16-bit RVC parcel in bits [15:0]) plus a format select and a tag, and produces a sign- or zero-extended XLEN-bit immediate with an illegal-format flag.
- Decoupled by a valid/ready handshake with a 2-entry skid buffer, so backpressure from execute never breaks the fetch/decode timing path.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64.
- RVC_EN, 1, when 1 the compressed formats are decoded; when 0 they are flagged illegal.
- TAG_W, 8, width of the sideband tag carried alongside each immediate.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush; drops all buffered entries
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  block can accept this cycle
- in_instr  input  32  instruction word; RVC parcel in [15:0]
- in_sel  input  4  format select (encoding below)
- in_tag  input  TAG_W  sideband tag, passed through unchanged
- out_valid  output  1  out_* holds a valid entry
- out_ready  input  1  downstream accepts this cycle
- out_imm  output  XLEN  generated immediate
- out_tag  output  TAG_W  tag of the entry on out_imm
- out_illegal  output  1  select or field is illegal for this configuration

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous, active-high.
- in_sel encoding:
  - 0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 6=ZIMM
  - 8=C_I, 9=C_J, 10=C_B, 11=C_LW
  - all other values are reserved.
- Format rules. Here i = in_instr and sx() means sign-extend to XLEN.
  - I: sx(i[31:20]).
  - S: sx({i[31:25], i[11:7]}).
  - B: sx({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: sx({i[31:12], 12'b0}). For XLEN=32 this is the 32-bit value unchanged.
  - J: sx({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - SHAMT, XLEN=64: zero-extended i[25:20].
  - SHAMT, XLEN=32: zero-extended i[24:20]; illegal=1 if i[25]=1.
  - ZIMM: zero-extended i[19:15].
  - C_I: sx({i[12], i[6:2]}).
  - C_J: sx of the offset, where i[12:2] maps to offset bits [11|4|9:8|10|6|7|3:1|5] and offset[0]=0.
  - C_B: sx of the offset, where i[12:10] maps to [8|4:3], i[6:2] maps to [7:6|2:1|5], and offset[0]=0.
  - C_LW: zero-extended, with [5:3]=i[12:10], [2]=i[6], [6]=i[5], [1:0]=0.
  - Compressed formats with RVC_EN=0, and any reserved select: out_imm=0 and out_illegal=1.
  - No X is ever driven on any output.
- Immediate computation is combinational from the inputs and is captured into the buffer when accepted.
- Buffer: 2-entry FIFO holding {imm, tag, illegal}, with occupancy count 0..2.
  - in_ready = !reset && !flush && (count != 2). It is combinational and does not depend on out_ready.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - Latency: an entry accepted at edge N is visible on out_* after edge N; out_valid is high in cycle N+1.
  - Throughput is 1 per cycle while out_ready is held high.
  - Simultaneous push and pop at count=1: count stays 1 and the head advances to the new entry.
  - At count=2 no push is possible; a pop returns count to 1.
  - Order is strictly FIFO.
  - out_imm, out_tag and out_illegal hold their values while out_valid && !out_ready. They are stable until the pop.
  - When empty, out_valid=0 and out_* hold the last value; these values are don't-care but never X.
- Flush:
  - On the next edge count becomes 0 and out_valid becomes 0.
  - A push presented in the same cycle is not accepted (in_ready is already 0).
  - A pop in the same cycle is irrelevant.
- Reset (also applies mid-operation):
  - All entries are dropped: count=0, out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
  - in_ready=0 while reset is high and 1 in the first cycle after reset deasserts.
- Priority: reset > flush > push/pop.

Test Plan:
- XLEN=64. Push 0xFFF00093 with sel=I, then 0xFE000EE3 with sel=B, out_ready=1 → out_imm=0xFFFFFFFFFFFFFFFF, then 0xFFFFFFFFFFFFFFFC, on consecutive cycles, 1-cycle latency, illegal=0.
- XLEN=64, U format. 0x123450B7 → 0x0000000012345000; 0x800000B7 → 0xFFFFFFFF80000000. XLEN=32: 0x800000B7 → 0x80000000.
- SHAMT. XLEN=64, 0x02109093 → imm=33, illegal=0. XLEN=32, same word → illegal=1.
- RVC. RVC_EN=1: C_J with in_instr=0x0000BFFD → imm=0xFFFFFFFFFFFFFFFE. RVC_EN=0, same stimulus → imm=0, illegal=1. Reserved sel=15 → imm=0, illegal=1.
- Backpressure. out_ready=0; offer tags 1,2,3 → tags 1 and 2 accepted, in_ready=0 on the third. out_* stable with tag=1. Raise out_ready → tags 1,2,3 emitted in order, with no loss or duplication.
- Flush and reset. With 2 entries held, pulse flush → next cycle out_valid=0, in_ready=1. Refill with 1 entry, assert reset for 1 cycle → all outputs 0, in_ready=0 during reset and 1 after.
